// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths and lane-packing helpers for the FFT datapath buffers
package fft_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int CPLX_W     = 2 * DEF_DATA_W;

  // Width of a counter that must represent 0..n inclusive; never narrower than 1 bit.
  function automatic int clog2_p1(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int lane_lsb(input int lane, input int data_w);
    return lane * data_w;
  endfunction

endpackage

// File: rtl/cplx_pipe_stage.sv
// rtl/cplx_pipe_stage.sv - one pipeline stage: valid flag plus LANES complex words
module cplx_pipe_stage
  import fft_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    load_i,
  input  logic                    up_valid_i,
  input  logic [LANES*DATA_W-1:0] up_re_i,
  input  logic [LANES*DATA_W-1:0] up_img_i,
  output logic                    valid_o,
  output logic [LANES*DATA_W-1:0] re_o,
  output logic [LANES*DATA_W-1:0] img_o
);

  logic                    valid_q, valid_d;
  logic [LANES*DATA_W-1:0] re_q, re_d;
  logic [LANES*DATA_W-1:0] img_q, img_d;

  // Data only moves with a real beat so idle stages do not toggle.
  always_comb begin
    valid_d = valid_q;
    re_d    = re_q;
    img_d   = img_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = up_valid_i;
      if (up_valid_i) begin
        for (int l = 0; l < LANES; l++) begin
          re_d[lane_lsb(l, DATA_W) +: DATA_W]  = up_re_i[lane_lsb(l, DATA_W) +: DATA_W];
          img_d[lane_lsb(l, DATA_W) +: DATA_W] = up_img_i[lane_lsb(l, DATA_W) +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      re_q    <= '0;
      img_q   <= '0;
    end else begin
      valid_q <= valid_d;
      re_q    <= re_d;
      img_q   <= img_d;
    end
  end

  assign valid_o = valid_q;
  assign re_o    = re_q;
  assign img_o   = img_q;

endmodule

// File: rtl/cplx_pipe_buf.sv
// rtl/cplx_pipe_buf.sv - DEPTH-stage complex sample buffer with bubble-collapsing valid/ready
module cplx_pipe_buf
  import fft_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANES  = 3,
  parameter int DEPTH  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_W-1:0]       in_re,
  input  logic [LANES*DATA_W-1:0]       in_img,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_W-1:0]       out_re,
  output logic [LANES*DATA_W-1:0]       out_img,
  output logic [clog2_p1(DEPTH)-1:0]    occupancy
);

  localparam int OCC_W = clog2_p1(DEPTH);
  localparam int BUS_W = LANES * DATA_W;

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] up_v;
  logic [DEPTH-1:0] v_next;
  logic [BUS_W-1:0] st_re  [DEPTH];
  logic [BUS_W-1:0] st_img [DEPTH];
  logic [BUS_W-1:0] up_re  [DEPTH];
  logic [BUS_W-1:0] up_img [DEPTH];
  logic [OCC_W-1:0] occ_q, occ_d;

  // A stage may advance if any stage at or downstream of it is empty, or the sink accepts.
  always_comb begin
    logic acc;
    acc = out_ready;
    adv = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc    = acc | !v[k];
      adv[k] = acc;
    end
  end

  assign in_ready = adv[0] & !flush;

  always_comb begin
    up_v    = '0;
    up_v[0] = in_valid & in_ready;
    for (int k = 1; k < DEPTH; k++) begin
      up_v[k] = v[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign up_re[k]  = in_re;
      assign up_img[k] = in_img;
    end else begin : g_body
      assign up_re[k]  = st_re[k-1];
      assign up_img[k] = st_img[k-1];
    end

    cplx_pipe_stage #(
      .DATA_W (DATA_W),
      .LANES  (LANES)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (flush),
      .load_i     (adv[k]),
      .up_valid_i (up_v[k]),
      .up_re_i    (up_re[k]),
      .up_img_i   (up_img[k]),
      .valid_o    (v[k]),
      .re_o       (st_re[k]),
      .img_o      (st_img[k])
    );
  end

  // Occupancy is registered alongside the stage valids, from their next-state values.
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      v_next[k] = flush ? 1'b0 : (adv[k] ? up_v[k] : v[k]);
      occ_d     = occ_d + OCC_W'(v_next[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
  assign out_valid = v[DEPTH-1];
  assign out_re    = st_re[DEPTH-1];
  assign out_img   = st_img[DEPTH-1];

endmodule

// File: tb/tb_cplx_pipe_buf.sv
// tb/tb_cplx_pipe_buf.sv - self-checking bench for cplx_pipe_buf with a beat-queue reference model
module tb_cplx_pipe_buf;

  localparam int DATA_W = 16;
  localparam int LANES  = 3;
  localparam int DEPTH  = 3;
  localparam int BW     = DATA_W * LANES;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_re = '0;
  logic [BW-1:0] in_img = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_re;
  logic [BW-1:0] out_img;
  logic [1:0]    occupancy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cplx_pipe_buf #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_img    (in_img),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_img   (out_img),
    .occupancy (occupancy)
  );

  // Reference: ordered queue of beats, each tagged with the stage it currently sits in.
  typedef struct {
    logic [BW-1:0] re;
    logic [BW-1:0] img;
    int            pos;
  } beat_t;
  beat_t mq[$];

  function automatic bit m_ov();
    return (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
  endfunction

  function automatic bit m_ir(input logic fl, input logic ordy);
    return !fl && ((mq.size() < DEPTH) || ordy);
  endfunction

  task automatic m_update();
    bit pop, acc;
    if (!rst_n || flush) begin
      mq.delete();
      return;
    end
    pop = m_ov() && out_ready;
    acc = in_valid && m_ir(flush, out_ready);
    // A beat moves if there is a free slot somewhere ahead of it, or the head leaves.
    for (int i = 0; i < mq.size(); i++) begin
      if (pop || (i < DEPTH - 1 - mq[i].pos)) mq[i].pos++;
    end
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back('{re: in_re, img: in_img, pos: 0});
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic ordy,
                       input logic [BW-1:0] re, input logic [BW-1:0] img);
    flush     = fl;
    in_valid  = iv;
    out_ready = ordy;
    in_re     = re;
    in_img    = img;
    #1;
  endtask

  task automatic check_model();
    chk("in_ready", 64'(in_ready), 64'(m_ir(flush, out_ready)));
    chk("out_valid", 64'(out_valid), 64'(m_ov()));
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    if (m_ov()) begin
      chk("out_re", 64'(out_re), 64'(mq[0].re));
      chk("out_img", 64'(out_img), 64'(mq[0].img));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic step(input logic fl, input logic iv, input logic ordy,
                      input logic [BW-1:0] re, input logic [BW-1:0] img);
    drive(fl, iv, ordy, re, img);
    check_model();
    advance();
  endtask

  typedef struct {
    logic        fl, iv, ordy;
    logic [15:0] re0;
    logic        e_ir, e_ov;
    logic [1:0]  e_occ;
    logic [15:0] e_re0;
  } vec_t;
  vec_t vt[19];

  initial begin
    // Latency stream 1..4 with no stall
    vt[0]  = '{1'b0, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 2'd0, 16'h0000};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 2'd1, 16'h0000};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 1'b0, 2'd2, 16'h0000};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b1, 1'b1, 2'd3, 16'h0001};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 2'd3, 16'h0002};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 2'd2, 16'h0003};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 2'd1, 16'h0004};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 2'd0, 16'h0000};
    // Back-pressure: five beats against a stalled sink, then release
    vt[8]  = '{1'b0, 1'b1, 1'b0, 16'h00A0, 1'b1, 1'b0, 2'd0, 16'h0000};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 16'h00A1, 1'b1, 1'b0, 2'd1, 16'h0000};
    vt[10] = '{1'b0, 1'b1, 1'b0, 16'h00A2, 1'b1, 1'b0, 2'd2, 16'h0000};
    vt[11] = '{1'b0, 1'b1, 1'b0, 16'h00A3, 1'b0, 1'b1, 2'd3, 16'h00A0};
    vt[12] = '{1'b0, 1'b1, 1'b0, 16'h00A3, 1'b0, 1'b1, 2'd3, 16'h00A0};
    vt[13] = '{1'b0, 1'b1, 1'b1, 16'h00A3, 1'b1, 1'b1, 2'd3, 16'h00A0};
    vt[14] = '{1'b0, 1'b1, 1'b1, 16'h00A4, 1'b1, 1'b1, 2'd3, 16'h00A1};
    vt[15] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 2'd3, 16'h00A2};
    vt[16] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 2'd2, 16'h00A3};
    vt[17] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 2'd1, 16'h00A4};
    vt[18] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 2'd0, 16'h0000};

    // Reset held for three cycles with traffic offered
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, BW'(48'h5555_6666_7777), BW'(48'h1234_5678_9ABC));
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_out_re", 64'(out_re), 64'd0);
      chk("rst_out_img", 64'(out_img), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      advance();
    end
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    rst_n = 1'b1;
    advance();

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].fl, vt[i].iv, vt[i].ordy, BW'(vt[i].re0), BW'(vt[i].re0) ^ BW'(48'hFFFF));
      check_model();
      chk("tbl_in_ready", 64'(in_ready), 64'(vt[i].e_ir));
      chk("tbl_out_valid", 64'(out_valid), 64'(vt[i].e_ov));
      chk("tbl_occupancy", 64'(occupancy), 64'(vt[i].e_occ));
      if (vt[i].e_ov) chk("tbl_out_re0", 64'(out_re[15:0]), 64'(vt[i].e_re0));
      advance();
    end

    // Bubble collapse: lone beat reaches the tail, second beat must close up behind it
    step(1'b0, 1'b1, 1'b0, BW'(16'h00B1), '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, BW'(16'h00B2), '0);
    step(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check_model();
    chk("bub_occupancy", 64'(occupancy), 64'd2);
    chk("bub_in_ready", 64'(in_ready), 64'd1);
    chk("bub_out_re0", 64'(out_re[15:0]), 64'h00B1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, '0, '0);

    // Flush of a full buffer with input offered in the same cycle
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, BW'(16'h00F0 + i), '0);
    drive(1'b1, 1'b1, 1'b0, BW'(16'h00F3), '0);
    check_model();
    chk("fl_in_ready", 64'(in_ready), 64'd0);
    advance();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    check_model();
    chk("fl_occupancy", 64'(occupancy), 64'd0);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    advance();

    // Asynchronous reset between edges with two beats in flight
    step(1'b0, 1'b1, 1'b0, BW'(16'h00C0), '0);
    step(1'b0, 1'b1, 1'b0, BW'(16'h00C1), '0);
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    chk("ar_pre_occupancy", 64'(occupancy), 64'd2);
    rst_n = 1'b0;
    #1;
    mq.delete();
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_occupancy", 64'(occupancy), 64'd0);
    chk("ar_out_re", 64'(out_re), 64'd0);
    advance();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, '0, '0);
      chk("ar_no_stale", 64'(out_valid), 64'd0);
      check_model();
      advance();
    end

    // Bit-exact lane placement
    step(1'b0, 1'b1, 1'b1, BW'(48'h3333_2222_1111), BW'(48'hFFFF_7FFF_8001));
    step(1'b0, 1'b0, 1'b1, '0, '0);
    step(1'b0, 1'b0, 1'b1, '0, '0);
    drive(1'b0, 1'b0, 1'b1, '0, '0);
    chk("lane_out_valid", 64'(out_valid), 64'd1);
    chk("lane_out_re", 64'(out_re), 64'h3333_2222_1111);
    chk("lane_out_img", 64'(out_img), 64'hFFFF_7FFF_8001);
    advance();

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 20) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
           BW'({$urandom, $urandom}), BW'({$urandom, $urandom}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
